// File: rtl/dog_extrema_detect_pkg.sv
// Shared constants and types for the DoG scale-space extrema detector.
// Window taps are numbered row-major 0..8 (top-left first), centre = 4.
package dog_extrema_detect_pkg;

    localparam int N_TAPS     = 9;
    localparam int TAP_CENTER = 4;
    localparam int N_NEIGH    = 26;
    localparam int COORD_W    = 16;

    typedef enum logic [1:0] {
        KP_NONE = 2'd0,
        KP_MIN  = 2'd1,
        KP_MAX  = 2'd2
    } kpKind_e;

    // Flat neighbour slot for (layer, tap); layer 0 = s-1, 1 = s, 2 = s+1.
    // The centre tap of layer 1 has no slot.
    function automatic int neighIdx(input int layer, input int tap);
        if (layer == 0) begin
            return tap;
        end
        if (layer == 1) begin
            return (tap < TAP_CENTER) ? (N_TAPS + tap) : (N_TAPS - 1 + tap);
        end
        return 2 * N_TAPS - 1 + tap;
    endfunction

endpackage

// File: rtl/dog_extrema_detect_if.sv
// Sample stream in, keypoint events and frame statistics out.
interface dog_extrema_detect_if #(
    parameter int dataW = 9,
    parameter int CNT_W = 16
);
    import dog_extrema_detect_pkg::*;

    logic                    en_p;
    logic                    frame_start;
    logic signed [dataW-1:0] dog_prev;
    logic signed [dataW-1:0] dog_cur;
    logic signed [dataW-1:0] dog_next;

    logic                    kp_valid;
    logic                    kp_is_max;
    logic [COORD_W-1:0]      kp_x;
    logic [COORD_W-1:0]      kp_y;
    logic signed [dataW-1:0] kp_val;
    logic                    frame_done;
    logic [CNT_W-1:0]        kp_count;

    modport master (
        output en_p, frame_start, dog_prev, dog_cur, dog_next,
        input  kp_valid, kp_is_max, kp_x, kp_y, kp_val, frame_done, kp_count
    );

    modport slave (
        input  en_p, frame_start, dog_prev, dog_cur, dog_next,
        output kp_valid, kp_is_max, kp_x, kp_y, kp_val, frame_done, kp_count
    );

endinterface

// File: rtl/dog_extrema_detect_win3x3.sv
// Two raster line buffers plus a 3x3 register window for one DoG layer.
// After the beat carrying pixel (x,y) the window covers columns x-2..x, rows y-2..y.
module dog_extrema_detect_win3x3
    import dog_extrema_detect_pkg::*;
#(
    parameter  int dataW   = 9,
    parameter  int FRAME_W = 200,
    localparam int AW      = $clog2(FRAME_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_adv,
    input  logic [AW-1:0]                 i_x,
    input  logic [dataW-1:0]              i_pix,
    output logic [N_TAPS-1:0][dataW-1:0]  o_win
);

    logic [dataW-1:0]             r_lb1 [FRAME_W];
    logic [dataW-1:0]             r_lb2 [FRAME_W];
    logic [dataW-1:0]             w_up1;
    logic [dataW-1:0]             w_up2;
    logic [N_TAPS-1:0][dataW-1:0] r_win;

    assign w_up1 = r_lb1[i_x];
    assign w_up2 = r_lb2[i_x];

    // Line RAM is deliberately left out of reset; stale rows are masked downstream.
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_lb1[i_x] <= i_pix;
            r_lb2[i_x] <= w_up1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (i_adv) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r*3]     <= r_win[r*3+1];
                r_win[r*3+1]   <= r_win[r*3+2];
            end
            r_win[2] <= w_up2;
            r_win[5] <= w_up1;
            r_win[8] <= i_pix;
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/dog_extrema_detect.sv
// Strict 3x3x3 extremum detector over three DoG layers with contrast/border
// qualification, keypoint events and a per-frame keypoint count.
module dog_extrema_detect
    import dog_extrema_detect_pkg::*;
#(
    parameter int dataW       = 9,
    parameter int FRAME_W     = 200,
    parameter int FRAME_H     = 200,
    parameter int BORDER      = 1,
    parameter int CONTRAST_TH = 3,
    parameter int CNT_W       = 16
) (
    input logic                  pixClk,
    input logic                  rst,
    dog_extrema_detect_if.slave  bus
);

    localparam int AW = $clog2(FRAME_W);
    localparam int MW = dataW + 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - 1);
    localparam logic [COORD_W-1:0] X_LO   = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] X_HI   = COORD_W'(FRAME_W - 1 - BORDER);
    localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(FRAME_H - 1 - BORDER);
    localparam logic [COORD_W-1:0] X_FD   = COORD_W'(FRAME_W - 2);
    localparam logic [COORD_W-1:0] Y_FD   = COORD_W'(FRAME_H - 2);
    localparam logic [MW-1:0]      MAG_TH = MW'(CONTRAST_TH);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               r_armed;
    logic               w_advP0;

    logic [N_TAPS-1:0][dataW-1:0] w_winPrev;
    logic [N_TAPS-1:0][dataW-1:0] w_winCur;
    logic [N_TAPS-1:0][dataW-1:0] w_winNext;

    logic                    r_v0;
    logic [COORD_W-1:0]      r_cx0;
    logic [COORD_W-1:0]      r_cy0;

    logic signed [dataW-1:0] w_nb [N_NEIGH];
    logic signed [dataW-1:0] w_cen;
    logic [N_NEIGH-1:0]      w_gt;
    logic [N_NEIGH-1:0]      w_lt;

    logic                    r_v1;
    logic [N_NEIGH-1:0]      r_gt;
    logic [N_NEIGH-1:0]      r_lt;
    logic signed [dataW-1:0] r_cen;
    logic [COORD_W-1:0]      r_cx1;
    logic [COORD_W-1:0]      r_cy1;

    kpKind_e                 w_kind;
    logic [MW-1:0]           w_cenExt;
    logic [MW-1:0]           w_mag;
    logic                    w_magOk;
    logic                    w_borderOk;
    logic                    w_hit;
    logic                    w_lastCenter;
    logic [CNT_W-1:0]        w_runNext;

    logic                    r_kpValid;
    logic                    r_kpIsMax;
    logic [COORD_W-1:0]      r_kpX;
    logic [COORD_W-1:0]      r_kpY;
    logic signed [dataW-1:0] r_kpVal;
    logic                    r_frameDone;
    logic [CNT_W-1:0]        r_kpCount;
    logic [CNT_W-1:0]        r_run;

    // frame_start overrides the raster counters for the sample it accompanies.
    always_comb begin
        w_x = bus.frame_start ? '0 : r_x;
        w_y = bus.frame_start ? '0 : r_y;
    end

    // Nothing is considered valid after reset until a frame_start has been seen.
    assign w_advP0 = bus.en_p & (r_armed | bus.frame_start);

    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_armed <= 1'b0;
        end else if (bus.en_p) begin
            if (bus.frame_start) begin
                r_armed <= 1'b1;
            end
            if (w_x == X_LAST) begin
                r_x <= '0;
                r_y <= (w_y == Y_LAST) ? '0 : w_y + 1'b1;
            end else begin
                r_x <= w_x + 1'b1;
                r_y <= w_y;
            end
        end
    end

    dog_extrema_detect_win3x3 #(.dataW(dataW), .FRAME_W(FRAME_W)) u_winPrev (
        .clk(pixClk), .rst(rst), .i_adv(bus.en_p), .i_x(w_x[AW-1:0]),
        .i_pix(bus.dog_prev), .o_win(w_winPrev)
    );

    dog_extrema_detect_win3x3 #(.dataW(dataW), .FRAME_W(FRAME_W)) u_winCur (
        .clk(pixClk), .rst(rst), .i_adv(bus.en_p), .i_x(w_x[AW-1:0]),
        .i_pix(bus.dog_cur), .o_win(w_winCur)
    );

    dog_extrema_detect_win3x3 #(.dataW(dataW), .FRAME_W(FRAME_W)) u_winNext (
        .clk(pixClk), .rst(rst), .i_adv(bus.en_p), .i_x(w_x[AW-1:0]),
        .i_pix(bus.dog_next), .o_win(w_winNext)
    );

    // The window centre sits one column and one row behind the incoming pixel.
    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            r_v0  <= 1'b0;
            r_cx0 <= '0;
            r_cy0 <= '0;
        end else if (bus.en_p) begin
            r_v0  <= w_advP0;
            r_cx0 <= w_x - 1'b1;
            r_cy0 <= w_y - 1'b1;
        end
    end

    always_comb begin
        w_cen = w_winCur[TAP_CENTER];
        for (int i = 0; i < N_NEIGH; i++) begin
            w_nb[i] = '0;
        end
        for (int t = 0; t < N_TAPS; t++) begin
            w_nb[neighIdx(0, t)] = w_winPrev[t];
            w_nb[neighIdx(2, t)] = w_winNext[t];
            if (t != TAP_CENTER) begin
                w_nb[neighIdx(1, t)] = w_winCur[t];
            end
        end
    end

    always_comb begin
        w_gt = '0;
        w_lt = '0;
        for (int i = 0; i < N_NEIGH; i++) begin
            w_gt[i] = (w_cen > w_nb[i]);
            w_lt[i] = (w_cen < w_nb[i]);
        end
    end

    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_gt  <= '0;
            r_lt  <= '0;
            r_cen <= '0;
            r_cx1 <= '0;
            r_cy1 <= '0;
        end else if (bus.en_p) begin
            r_v1  <= r_v0;
            r_gt  <= w_gt;
            r_lt  <= w_lt;
            r_cen <= w_cen;
            r_cx1 <= r_cx0;
            r_cy1 <= r_cy0;
        end
    end

    // One extra bit keeps |most-negative| representable.
    always_comb begin
        w_kind = KP_NONE;
        if (&r_gt) begin
            w_kind = KP_MAX;
        end else if (&r_lt) begin
            w_kind = KP_MIN;
        end
        w_cenExt     = {r_cen[dataW-1], r_cen};
        w_mag        = r_cen[dataW-1] ? (~w_cenExt + 1'b1) : w_cenExt;
        w_magOk      = (w_mag >= MAG_TH);
        w_borderOk   = (r_cx1 >= X_LO) && (r_cx1 <= X_HI) &&
                       (r_cy1 >= Y_LO) && (r_cy1 <= Y_HI);
        w_hit        = r_v1 && (w_kind != KP_NONE) && w_magOk && w_borderOk;
        w_lastCenter = r_v1 && (r_cx1 == X_FD) && (r_cy1 == Y_FD);
        w_runNext    = (w_hit && (r_run != '1)) ? r_run + 1'b1 : r_run;
    end

    // Pulses drop on any cycle without en_p; event fields hold until the next hit.
    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            r_kpValid   <= 1'b0;
            r_kpIsMax   <= 1'b0;
            r_kpX       <= '0;
            r_kpY       <= '0;
            r_kpVal     <= '0;
            r_frameDone <= 1'b0;
            r_kpCount   <= '0;
            r_run       <= '0;
        end else begin
            r_kpValid   <= 1'b0;
            r_frameDone <= 1'b0;
            if (bus.en_p) begin
                r_kpValid   <= w_hit;
                r_frameDone <= w_lastCenter;
                if (w_hit) begin
                    r_kpIsMax <= (w_kind == KP_MAX);
                    r_kpX     <= r_cx1;
                    r_kpY     <= r_cy1;
                    r_kpVal   <= r_cen;
                end
                if (w_lastCenter) begin
                    r_kpCount <= w_runNext;
                    r_run     <= '0;
                end else begin
                    r_run     <= w_runNext;
                end
            end
        end
    end

    assign bus.kp_valid   = r_kpValid;
    assign bus.kp_is_max  = r_kpIsMax;
    assign bus.kp_x       = r_kpX;
    assign bus.kp_y       = r_kpY;
    assign bus.kp_val     = r_kpVal;
    assign bus.frame_done = r_frameDone;
    assign bus.kp_count   = r_kpCount;

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Directed-frame bench for dog_extrema_detect on an 8x8 raster, checked
// every cycle against a neighbourhood-scanning reference model.
module tb_dog_extrema_detect;

    localparam int DW     = 9;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int BORDER = 1;
    localparam int TH     = 10;
    localparam int CW     = 16;

    logic pixClk;
    logic rst;

    dog_extrema_detect_if #(.dataW(DW), .CNT_W(CW)) bus ();

    dog_extrema_detect #(
        .dataW(DW), .FRAME_W(W), .FRAME_H(H), .BORDER(BORDER),
        .CONTRAST_TH(TH), .CNT_W(CW)
    ) dut (
        .pixClk(pixClk),
        .rst(rst),
        .bus(bus)
    );

    initial pixClk = 1'b0;
    always #5 pixClk = ~pixClk;

    typedef struct {int due; int x; int y; int val; bit isMax;} kpEv_t;
    typedef struct {int due; int cnt;} fdEv_t;

    kpEv_t evQ[$];
    fdEv_t fdQ[$];
    int fPrev [H][W];
    int fCur  [H][W];
    int fNext [H][W];

    int beatNo   = 0;
    bit lastBeat = 1'b0;
    int expCount = 0;
    int checks   = 0;
    int passes   = 0;
    int kpSeen   = 0;
    int fdSeen   = 0;
    int lastX, lastY, lastVal;
    bit lastMax;
    int prevX = 0, prevY = 0, prevVal = 0;
    bit prevMax = 1'b0, prevRst = 1'b1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int sampleAt(input int layer, input int y, input int x);
        if (layer == 0) return fPrev[y][x];
        if (layer == 1) return fCur[y][x];
        return fNext[y][x];
    endfunction

    // Reference: scan every interior pixel against its 26 neighbours.
    task automatic buildExpect(input int base);
        int cnt, c, n, mag;
        bit allGt, allLt;
        cnt = 0;
        for (int cy = BORDER; cy <= H - 1 - BORDER; cy++) begin
            for (int cx = BORDER; cx <= W - 1 - BORDER; cx++) begin
                c = fCur[cy][cx];
                allGt = 1'b1;
                allLt = 1'b1;
                for (int l = 0; l < 3; l++)
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            if (l == 1 && dy == 0 && dx == 0) continue;
                            n = sampleAt(l, cy + dy, cx + dx);
                            if (c <= n) allGt = 1'b0;
                            if (c >= n) allLt = 1'b0;
                        end
                mag = (c < 0) ? -c : c;
                if ((allGt || allLt) && mag >= TH) begin
                    evQ.push_back('{base + (cy + 1) * W + (cx + 1) + 1 + 2, cx, cy, c, allGt});
                    cnt++;
                end
            end
        end
        fdQ.push_back('{base + W * H + 2, cnt});
    endtask

    task automatic tick();
        @(posedge pixClk);
        lastBeat = bus.en_p;
        if (bus.en_p) beatNo++;
        #1;
    endtask

    task automatic clearFrames();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                fPrev[y][x] = 0;
                fCur[y][x]  = 0;
                fNext[y][x] = 0;
            end
    endtask

    task automatic applyStimulus(input bit toggle, input int nBeats);
        int x, y, idle;
        kpSeen = 0;
        fdSeen = 0;
        buildExpect(beatNo);
        for (int n = 0; n < nBeats; n++) begin
            idle = toggle ? (((n % 2) == 0 ? 1 : 0) + int'($urandom_range(0, 1))) : 0;
            repeat (idle) begin
                bus.en_p        = 1'b0;
                bus.frame_start = 1'b0;
                bus.dog_prev    = DW'($urandom);
                bus.dog_cur     = DW'($urandom);
                bus.dog_next    = DW'($urandom);
                tick();
            end
            y = n / W;
            x = n % W;
            bus.en_p        = 1'b1;
            bus.frame_start = (n == 0);
            bus.dog_prev    = DW'(fPrev[y][x]);
            bus.dog_cur     = DW'(fCur[y][x]);
            bus.dog_next    = DW'(fNext[y][x]);
            tick();
        end
        if (nBeats == W * H) begin
            repeat (3) begin
                bus.en_p        = 1'b1;
                bus.frame_start = 1'b0;
                bus.dog_prev    = '0;
                bus.dog_cur     = '0;
                bus.dog_next    = '0;
                tick();
            end
        end
        bus.en_p        = 1'b0;
        bus.frame_start = 1'b0;
        repeat (2) tick();
    endtask

    task automatic checkOutput(input string nm, input int expSeen, input int ex, input int ey,
                               input int ev, input bit emax, input int ecnt);
        check({nm, " kp pulses"}, kpSeen, expSeen);
        check({nm, " frame_done pulses"}, fdSeen, 1);
        if (expSeen > 0) begin
            check({nm, " kp_x"}, lastX, ex);
            check({nm, " kp_y"}, lastY, ey);
            check({nm, " kp_val"}, lastVal, ev);
            check({nm, " kp_is_max"}, int'(lastMax), int'(emax));
        end
        check({nm, " kp_count"}, int'(bus.kp_count), ecnt);
    endtask

    always @(negedge pixClk) begin : compare
        bit expV, expFd;
        expV  = lastBeat && !rst && evQ.size() > 0 && evQ[0].due == beatNo;
        expFd = lastBeat && !rst && fdQ.size() > 0 && fdQ[0].due == beatNo;
        if (expFd) expCount = fdQ[0].cnt;
        check("kp_valid", int'(bus.kp_valid), int'(expV));
        check("frame_done", int'(bus.frame_done), int'(expFd));
        check("kp_count", int'(bus.kp_count), expCount);
        if (expV) begin
            check("event kp_x", int'(bus.kp_x), evQ[0].x);
            check("event kp_y", int'(bus.kp_y), evQ[0].y);
            check("event kp_val", int'(bus.kp_val), evQ[0].val);
            check("event kp_is_max", int'(bus.kp_is_max), int'(evQ[0].isMax));
            void'(evQ.pop_front());
        end
        if (expFd) void'(fdQ.pop_front());
        if (!lastBeat && !rst && !prevRst) begin
            check("hold kp_x", int'(bus.kp_x), prevX);
            check("hold kp_y", int'(bus.kp_y), prevY);
            check("hold kp_val", int'(bus.kp_val), prevVal);
            check("hold kp_is_max", int'(bus.kp_is_max), int'(prevMax));
        end
        if (bus.kp_valid) begin
            kpSeen++;
            lastX   = int'(bus.kp_x);
            lastY   = int'(bus.kp_y);
            lastVal = int'(bus.kp_val);
            lastMax = bus.kp_is_max;
        end
        if (bus.frame_done) fdSeen++;
        prevX   = int'(bus.kp_x);
        prevY   = int'(bus.kp_y);
        prevVal = int'(bus.kp_val);
        prevMax = bus.kp_is_max;
        prevRst = rst;
    end

    task automatic checkResetOutputs(input string nm);
        check({nm, " kp_valid"}, int'(bus.kp_valid), 0);
        check({nm, " kp_is_max"}, int'(bus.kp_is_max), 0);
        check({nm, " kp_x"}, int'(bus.kp_x), 0);
        check({nm, " kp_y"}, int'(bus.kp_y), 0);
        check({nm, " kp_val"}, int'(bus.kp_val), 0);
        check({nm, " frame_done"}, int'(bus.frame_done), 0);
        check({nm, " kp_count"}, int'(bus.kp_count), 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.en_p        = 1'b0;
        bus.frame_start = 1'b0;
        bus.dog_prev    = '0;
        bus.dog_cur     = '0;
        bus.dog_next    = '0;
        repeat (2) tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (2) tick();

        clearFrames();
        applyStimulus(1'b0, W * H);
        checkOutput("t1 zero", 0, 0, 0, 0, 1'b0, 0);

        clearFrames();
        fCur[4][4] = 50;
        applyStimulus(1'b0, W * H);
        checkOutput("t2 max", 1, 4, 4, 50, 1'b1, 1);

        clearFrames();
        fCur[4][4]  = -50;
        fNext[6][4] = -50;
        applyStimulus(1'b0, W * H);
        checkOutput("t3 min", 1, 4, 4, -50, 1'b0, 1);

        clearFrames();
        fCur[4][4]  = -50;
        fNext[4][4] = -50;
        applyStimulus(1'b0, W * H);
        checkOutput("t3 tie", 0, 0, 0, 0, 1'b0, 0);

        clearFrames();
        fCur[3][3] = 9;
        fCur[3][0] = 50;
        fCur[7][6] = 50;
        applyStimulus(1'b0, W * H);
        checkOutput("t4 reject", 0, 0, 0, 0, 1'b0, 0);

        clearFrames();
        fCur[2][2] = -256;
        applyStimulus(1'b0, W * H);
        checkOutput("t4 most-negative", 1, 2, 2, -256, 1'b0, 1);

        clearFrames();
        fCur[4][4] = 50;
        applyStimulus(1'b1, W * H);
        checkOutput("t5 en_p toggle", 1, 4, 4, 50, 1'b1, 1);

        clearFrames();
        fCur[4][4] = 50;
        applyStimulus(1'b0, 40);
        rst = 1'b1;
        evQ.delete();
        fdQ.delete();
        expCount = 0;
        #1;
        checkResetOutputs("t6 mid-frame reset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        applyStimulus(1'b0, W * H);
        checkOutput("t6 after reset", 1, 4, 4, 50, 1'b1, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
